dodec_reqsvc: RTL and testbench

- Request latch and service sequencer for 12 attention/request lines in IBM bit order: bit1 is the MSB of the vector, bit12 the LSB.
- Holds sticky pending bits and selects the highest-priority eligible request using the same 1-of-12 priority rule as the existing encoder: the right-most set bit, so bit12 wins.
- Presents the request number to the channel-side sequencer with a valid/ack handshake, then retires the bit.
- Sits between the device status/attention pulse sources and the control-unit microsequencer.

---
 rtl/dodec_reqsvc.sv | 132 +++++++++++++
 tb/tb_dodec_reqsvc.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dodec_reqsvc.sv
// Request latch and service sequencer for 12 attention lines in IBM bit order
// (bit1 = MSB, bit12 = LSB); offers the right-most eligible request over a valid/ack handshake.
module dodec_reqsvc #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [11:0] i_req,
    input  logic [11:0] i_mask,
    input  logic        i_clear,
    input  logic        i_ack,
    output logic        o_valid,
    output logic [3:0]  o_num,
    output logic        o_timeout,
    output logic [11:0] o_pending,
    output logic        o_any
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OFFER,
        S_GAP
    } state_t;

    localparam logic [TW-1:0] LP_TLIM = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t        r_state, w_state_nx;
    logic [11:0]   r_pending, w_pending_nx;
    logic          r_valid, w_valid_nx;
    logic [3:0]    r_num, w_num_nx;
    logic          r_timeout, w_timeout_nx;
    logic [TW-1:0] r_cnt, w_cnt_nx;

    logic [11:0]   w_eligible;
    logic [3:0]    w_sel;
    logic [11:0]   w_clr;

    // Vector index i holds bit number 12-i; the lowest set index wins.
    function automatic logic [3:0] f_encode(input logic [11:0] v);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < 12; i++) begin
            if (v[i] && n == '0) begin
                n = 4'(12 - i);
            end
        end
        return n;
    endfunction

    assign w_eligible = r_pending & ~i_mask;
    assign w_sel      = f_encode(w_eligible);

    always_comb begin
        w_state_nx   = r_state;
        w_valid_nx   = r_valid;
        w_num_nx     = r_num;
        w_timeout_nx = 1'b0;
        w_cnt_nx     = r_cnt;
        w_clr        = '0;

        case (r_state)
            S_IDLE: begin
                if (w_eligible != '0) begin
                    w_num_nx   = w_sel;
                    w_valid_nx = 1'b1;
                    w_cnt_nx   = '0;
                    w_state_nx = S_OFFER;
                end
            end
            S_OFFER: begin
                if (i_ack) begin
                    w_clr      = 12'h001 << (4'd12 - r_num);
                    w_valid_nx = 1'b0;
                    w_num_nx   = '0;
                    w_state_nx = S_GAP;
                end else if (TIMEOUT != 0 && r_cnt == LP_TLIM) begin
                    w_clr        = 12'h001 << (4'd12 - r_num);
                    w_timeout_nx = 1'b1;
                    w_valid_nx   = 1'b0;
                    w_num_nx     = '0;
                    w_state_nx   = S_GAP;
                end else if (r_cnt != '1) begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            S_GAP: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // A set arriving on the retire edge wins over the clear.
        w_pending_nx = (r_pending & ~w_clr) | i_req;

        if (i_clear) begin
            w_state_nx   = S_IDLE;
            w_valid_nx   = 1'b0;
            w_num_nx     = '0;
            w_timeout_nx = 1'b0;
            w_cnt_nx     = '0;
            w_pending_nx = i_req;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_valid   <= 1'b0;
            r_num     <= '0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_pending <= w_pending_nx;
            r_valid   <= w_valid_nx;
            r_num     <= w_num_nx;
            r_timeout <= w_timeout_nx;
            r_cnt     <= w_cnt_nx;
        end
    end

    assign o_valid   = r_valid;
    assign o_num     = r_num;
    assign o_timeout = r_timeout;
    assign o_pending = r_pending;
    assign o_any     = |r_pending;

endmodule

// File: tb/tb_dodec_reqsvc.sv
// Self-checking bench for dodec_reqsvc: offer numbers scoreboarded on each o_valid rise,
// per-scenario tasks check timing, pending state, timeout, mask, clear and reset.
module tb_dodec_reqsvc;

    logic        clk;
    logic        rst_n;
    logic [11:0] i_req;
    logic [11:0] i_mask;
    logic        i_clear;
    logic        i_ack;
    logic        o_valid;
    logic [3:0]  o_num;
    logic        o_timeout;
    logic [11:0] o_pending;
    logic        o_any;

    int n_checks = 0;
    int n_fail   = 0;

    int exp_q[$];
    logic prev_valid = 1'b0;

    dodec_reqsvc #(.TIMEOUT(4), .TW(8)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_req    (i_req),
        .i_mask   (i_mask),
        .i_clear  (i_clear),
        .i_ack    (i_ack),
        .o_valid  (o_valid),
        .o_num    (o_num),
        .o_timeout(o_timeout),
        .o_pending(o_pending),
        .o_any    (o_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: each new offer must carry the next queued request number.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
        end else begin
            if (o_valid && !prev_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL offer_unexpected: got num=%0d, expected no offer", o_num);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (o_num !== 4'(e)) begin
                        n_fail++;
                        $display("FAIL offer_num: got %0d, expected %0d", o_num, e);
                    end
                end
            end
            prev_valid <= o_valid;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic ack_once();
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_req = '0; i_mask = '0; i_clear = 1'b0; i_ack = 1'b0;
        tick(); tick();
        n_checks++;
        if ({o_valid, o_num, o_timeout, o_pending, o_any} !== 19'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b num=%0d to=%b pend=%h any=%b, expected all 0",
                     o_valid, o_num, o_timeout, o_pending, o_any);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        i_req = 12'h001; exp_q.push_back(12);
        tick();
        i_req = '0;
        n_checks++;
        if (o_pending !== 12'h001 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latch: got pend=%h v=%b, expected 001 v=0", o_pending, o_valid);
        end
        tick();
        n_checks++;
        if (o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_latency: got v=%b, expected 1", o_valid);
        end
        ack_once();
        n_checks++;
        if (o_pending !== 12'h000 || o_valid !== 1'b0 || o_num !== 4'd0) begin
            n_fail++;
            $display("FAIL single_retire: got pend=%h v=%b num=%0d, expected 000 0 0",
                     o_pending, o_valid, o_num);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (o_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL single_no_reoffer: got v=%b, expected 0 (cycle %0d)", o_valid, i);
            end
        end
    endtask

    task automatic test_order();
        logic [11:0] rem[3];
        bit ok;
        rem[0] = 12'h220; rem[1] = 12'h200; rem[2] = 12'h000;
        i_req = 12'h221;
        exp_q.push_back(12); exp_q.push_back(7); exp_q.push_back(3);
        tick();
        i_req = '0;
        wait_valid(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL order_first_offer: got no offer, expected one within 20 cycles");
        end
        for (int k = 0; k < 3; k++) begin
            ack_once();
            n_checks++;
            if (o_pending !== rem[k] || o_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL order_retire%0d: got pend=%h v=%b, expected %h v=0",
                         k, o_pending, o_valid, rem[k]);
            end
            tick();
            n_checks++;
            if (o_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL order_gap%0d: got v=%b, expected 0", k, o_valid);
            end
            tick();
            n_checks++;
            if (o_valid !== (k < 2)) begin
                n_fail++;
                $display("FAIL order_spacing%0d: got v=%b, expected %b", k, o_valid, (k < 2));
            end
        end
    endtask

    task automatic test_hold();
        bit ok;
        i_req = 12'h080; exp_q.push_back(5);
        tick();
        i_req = '0;
        wait_valid(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL hold_offer5: got no offer, expected offer 5");
        end
        i_req = 12'h002; exp_q.push_back(11);
        tick();
        i_req = '0;
        n_checks++;
        if (o_num !== 4'd5 || o_valid !== 1'b1 || o_pending !== 12'h082) begin
            n_fail++;
            $display("FAIL hold_stable1: got num=%0d v=%b pend=%h, expected 5 1 082",
                     o_num, o_valid, o_pending);
        end
        tick();
        n_checks++;
        if (o_num !== 4'd5 || o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_stable2: got num=%0d v=%b, expected 5 1", o_num, o_valid);
        end
        ack_once();
        wait_valid(ok);
        n_checks++;
        if (!ok || o_num !== 4'd11) begin
            n_fail++;
            $display("FAIL hold_next11: got ok=%b num=%0d, expected 1 11", ok, o_num);
        end
        ack_once();
    endtask

    task automatic test_timeout();
        bit ok;
        int hi;
        i_req = 12'h400; exp_q.push_back(2);
        tick();
        i_req = '0;
        wait_valid(ok);
        hi = ok ? 1 : 0;
        for (int i = 0; i < 10 && ok; i++) begin
            tick();
            if (o_valid === 1'b1) hi++;
            else break;
        end
        n_checks++;
        if (hi != 4) begin
            n_fail++;
            $display("FAIL timeout_valid_len: got %0d cycles, expected 4", hi);
        end
        n_checks++;
        if (o_timeout !== 1'b1 || o_pending !== 12'h000 || o_any !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse: got to=%b pend=%h any=%b, expected 1 000 0",
                     o_timeout, o_pending, o_any);
        end
        tick();
        n_checks++;
        if (o_timeout !== 1'b0 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_one_cycle: got to=%b v=%b, expected 0 0", o_timeout, o_valid);
        end
        tick(); tick();
    endtask

    task automatic test_mask();
        bit ok;
        i_mask = 12'h008;
        i_req  = 12'h108; exp_q.push_back(4);
        tick();
        i_req = '0;
        wait_valid(ok);
        n_checks++;
        if (!ok || o_num !== 4'd4) begin
            n_fail++;
            $display("FAIL mask_offer4: got ok=%b num=%0d, expected 1 4", ok, o_num);
        end
        i_mask = '0; exp_q.push_back(9);
        ack_once();
        wait_valid(ok);
        n_checks++;
        if (!ok || o_num !== 4'd9) begin
            n_fail++;
            $display("FAIL mask_unmask9: got ok=%b num=%0d, expected 1 9", ok, o_num);
        end
        ack_once();
        tick(); tick();
        i_req = 12'h100; exp_q.push_back(4);
        tick();
        i_req = '0;
        wait_valid(ok);
        exp_q.push_back(4);
        i_ack = 1'b1; i_req = 12'h100;
        tick();
        i_ack = 1'b0; i_req = '0;
        n_checks++;
        if (o_pending !== 12'h100 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_set_wins: got pend=%h v=%b, expected 100 0", o_pending, o_valid);
        end
        wait_valid(ok);
        ack_once();
        n_checks++;
        if (o_pending !== 12'h000) begin
            n_fail++;
            $display("FAIL mask_reoffer_retire: got pend=%h, expected 000", o_pending);
        end
        tick(); tick();
    endtask

    task automatic test_clear_reset();
        bit ok;
        i_req = 12'h080; exp_q.push_back(5);
        tick();
        i_req = '0;
        wait_valid(ok);
        i_clear = 1'b1; i_req = 12'h800; i_ack = 1'b1; exp_q.push_back(1);
        tick();
        i_clear = 1'b0; i_req = '0; i_ack = 1'b0;
        n_checks++;
        if (o_valid !== 1'b0 || o_num !== 4'd0 || o_pending !== 12'h800 || o_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_flush: got v=%b num=%0d pend=%h to=%b, expected 0 0 800 0",
                     o_valid, o_num, o_pending, o_timeout);
        end
        tick();
        n_checks++;
        if (o_valid !== 1'b1 || o_num !== 4'd1) begin
            n_fail++;
            $display("FAIL clear_next_offer: got v=%b num=%0d, expected 1 1", o_valid, o_num);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_valid, o_num, o_timeout, o_pending, o_any} !== 19'b0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b num=%0d to=%b pend=%h any=%b, expected all 0",
                     o_valid, o_num, o_timeout, o_pending, o_any);
        end
        tick();
        rst_n = 1'b1;
        tick(); tick();
        n_checks++;
        if (o_valid !== 1'b0 || o_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_quiet: got v=%b to=%b, expected 0 0", o_valid, o_timeout);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_order();
        test_hold();
        test_timeout();
        test_mask();
        test_clear_reset();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d offers missing, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
